// File: rtl/func_equiv_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : func_equiv_pkg
//  Description : Shared types and helpers for the equivalence scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package func_equiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic int num_vec(input int n);
    return 1 << n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/func_equiv_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : func_equiv_scanner_if
//  Description : Harness <-> scanner bundle (stimulus, functions, results).
//  Revision    : 1.0 - initial release
// ============================================================================
interface func_equiv_scanner_if
  import func_equiv_pkg::*;
#(
  parameter int N_IN = 4
);
  localparam int NUM_VEC = num_vec(N_IN);

  logic               start;
  logic               f_a;
  logic               f_b;
  logic [N_IN-1:0]    vec;
  logic               busy;
  logic               done;
  logic               equal;
  logic [N_IN:0]      mismatch_cnt;
  logic [N_IN-1:0]    first_mismatch;
  logic [NUM_VEC-1:0] tt_a;
  logic [NUM_VEC-1:0] tt_b;

  modport master (
    output start, f_a, f_b,
    input  vec, busy, done, equal, mismatch_cnt, first_mismatch, tt_a, tt_b
  );

  modport slave (
    input  start, f_a, f_b,
    output vec, busy, done, equal, mismatch_cnt, first_mismatch, tt_a, tt_b
  );

endinterface
`default_nettype wire

// File: rtl/func_equiv_scanner_vec_settle_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vec_settle_counter
//  Description : Walks vec through 0..2^N_IN-1, holding each value SETTLE cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_settle_counter #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            clear,
  input  wire logic            run,
  output logic [N_IN-1:0]      vec,
  output logic                 sample_pulse,
  output logic                 last_vec
);

  localparam int               c_sw          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [c_sw-1:0]  c_settle_last = c_sw'(SETTLE - 1);
  localparam logic [N_IN-1:0]  c_vec_last    = {N_IN{1'b1}};

  logic [c_sw-1:0] r_settle;
  logic [N_IN-1:0] r_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= '0;
      r_vec    <= '0;
    end else if (clear) begin
      r_settle <= '0;
      r_vec    <= '0;
    end else if (run) begin
      if (sample_pulse) begin
        r_settle <= '0;
        // vec is parked at 0 once the final vector has been sampled
        r_vec    <= last_vec ? '0 : r_vec + 1'b1;
      end else begin
        r_settle <= r_settle + 1'b1;
      end
    end
  end

  assign sample_pulse = run && (r_settle == c_settle_last);
  assign last_vec     = (r_vec == c_vec_last);
  assign vec          = r_vec;

endmodule
`default_nettype wire

// File: rtl/func_equiv_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : func_equiv_scanner
//  Description : Exhaustive equivalence scan of two N_IN-input functions.
//                Optional truth-table capture: FUNC_EQUIV_TT_CAPTURE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module func_equiv_scanner
  import func_equiv_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  func_equiv_scanner_if.slave bus
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic            w_start_acc;
  logic            w_run;
  logic            w_sample;
  logic            w_last;
  logic            w_mismatch;
  logic [N_IN-1:0] w_vec;
  logic [N_IN:0]   w_cnt_nxt;

  logic            r_busy;
  logic            r_done;
  logic            r_equal;
  logic [N_IN:0]   r_cnt;
  logic [N_IN-1:0] r_first;

  assign w_run = (r_state == SCAN);

  vec_settle_counter #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_vec_settle_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (w_start_acc),
    .run          (w_run),
    .vec          (w_vec),
    .sample_pulse (w_sample),
    .last_vec     (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_start_acc = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      SCAN:    if (w_sample && w_last) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_mismatch = bus.f_a ^ bus.f_b;
  assign w_cnt_nxt  = r_cnt + {{N_IN{1'b0}}, w_mismatch};

  // done/equal rise on the same edge that drops busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_equal <= 1'b0;
      r_cnt   <= '0;
      r_first <= '0;
    end else if (w_start_acc) begin
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_equal <= 1'b0;
      r_cnt   <= '0;
      r_first <= '0;
    end else if (w_sample) begin
      r_cnt <= w_cnt_nxt;
      if (w_mismatch && (r_cnt == '0)) r_first <= w_vec;
      if (w_last) begin
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_equal <= (w_cnt_nxt == '0);
      end
    end
  end

`ifdef FUNC_EQUIV_TT_CAPTURE_EN
  localparam int c_num_vec = num_vec(N_IN);

  logic [c_num_vec-1:0] r_tt_a;
  logic [c_num_vec-1:0] r_tt_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tt_a <= '0;
      r_tt_b <= '0;
    end else if (w_start_acc) begin
      r_tt_a <= '0;
      r_tt_b <= '0;
    end else if (w_sample) begin
      r_tt_a[w_vec] <= bus.f_a;
      r_tt_b[w_vec] <= bus.f_b;
    end
  end

  assign bus.tt_a = r_tt_a;
  assign bus.tt_b = r_tt_b;
`else
  assign bus.tt_a = '0;
  assign bus.tt_b = '0;
`endif

  assign bus.vec            = w_vec;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.equal          = r_equal;
  assign bus.mismatch_cnt   = r_cnt;
  assign bus.first_mismatch = r_first;

endmodule
`default_nettype wire

// File: tb/tb_func_equiv_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_func_equiv_scanner
//  Description : Randomised scans of two scanner instances against a timeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_func_equiv_scanner;

  localparam int N0 = 3, S0 = 2, NV0 = 8;
  localparam int N1 = 4, S1 = 1, NV1 = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  func_equiv_scanner_if #(.N_IN(N0)) bus0 ();
  func_equiv_scanner_if #(.N_IN(N1)) bus1 ();

  logic [7:0] ta = 8'h00;
  logic [7:0] tb = 8'h00;
  logic       ga = 1'b0;
  logic       mode1 = 1'b0;
  bit         chk_en = 1'b0;

  assign bus0.f_a = ta[bus0.vec] ^ ga;
  assign bus0.f_b = tb[bus0.vec];
  assign bus1.f_a = bus1.vec[0];
  assign bus1.f_b = bus1.vec[0] ^ mode1;

  func_equiv_scanner #(.N_IN(N0), .SETTLE(S0)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  func_equiv_scanner #(.N_IN(N1), .SETTLE(S1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int popcnt(input logic [7:0] x);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(x[i]);
    return n;
  endfunction

  function automatic int lowest(input logic [7:0] x);
    for (int i = 0; i < 8; i++) if (x[i]) return i;
    return 0;
  endfunction

  // Timeline model of u0: m_k is the 1-based cycle number within a scan
  int         m_k;
  bit         m_busy, m_done, m_fin, m_eq;
  int         m_cnt, m_first;
  logic [7:0] m_tta, m_ttb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k <= 0; m_busy <= 0; m_done <= 0; m_fin <= 0; m_eq <= 0;
      m_cnt <= 0; m_first <= 0; m_tta <= 0; m_ttb <= 0;
    end else if (!m_busy && !m_fin && bus0.start) begin
      m_busy <= 1; m_k <= 1; m_done <= 0; m_eq <= 0;
      m_cnt <= 0; m_first <= 0; m_tta <= 0; m_ttb <= 0;
    end else if (m_busy) begin
      if (m_k == NV0 * S0) begin
        m_busy  <= 0; m_fin <= 1; m_done <= 1;
        m_cnt   <= popcnt(ta ^ tb);
        m_first <= lowest(ta ^ tb);
        m_eq    <= (ta == tb);
        m_tta   <= ta;
        m_ttb   <= tb;
      end else begin
        m_k <= m_k + 1;
      end
    end else begin
      m_fin <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("busy", bus0.busy, m_busy);
      chk("done", bus0.done, m_done);
      chk("vec", bus0.vec, m_busy ? (m_k - 1) / S0 : 0);
      if (!m_busy) begin
        chk("equal", bus0.equal, m_eq);
        chk("mismatch_cnt", bus0.mismatch_cnt, m_cnt);
        chk("first_mismatch", bus0.first_mismatch, m_first);
`ifdef FUNC_EQUIV_TT_CAPTURE_EN
        chk("tt_a", bus0.tt_a, m_tta);
        chk("tt_b", bus0.tt_b, m_ttb);
`else
        chk("tt_a", bus0.tt_a, 0);
        chk("tt_b", bus0.tt_b, 0);
`endif
      end
    end
  end

  // One scan on u0; f_a glitches randomly on every non-sampling cycle when asked
  task automatic run_scan(input logic [7:0] a, input logic [7:0] b, input bit glitch,
                          input int poke_at, input bit fin_poke, output int nb);
    ta = a; tb = b;
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    nb = 0;
    for (int k = 1; k <= 100; k++) begin
      if (!bus0.busy) break;
      nb++;
      ga = (glitch && ((k - 1) % S0 != S0 - 1)) ? 1'($urandom) : 1'b0;
      bus0.start = (k == poke_at);
      @(negedge clk);
    end
    ga = 1'b0; bus0.start = 1'b0;
    if (bus0.busy) chk("scan_timeout", 1, 0);
    if (fin_poke) begin
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run1(output int nb);
    @(negedge clk); bus1.start = 1'b1;
    @(negedge clk); bus1.start = 1'b0;
    nb = 0;
    for (int k = 1; k <= 100; k++) begin
      if (!bus1.busy) break;
      nb++;
      @(negedge clk);
    end
    if (bus1.busy) chk("scan1_timeout", 1, 0);
  endtask

  logic [7:0] sop, pos;
  int nb;

  initial begin
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_cnt", bus0.mismatch_cnt, 0);
    chk("rst_tt_a", bus0.tt_a, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    for (int v = 0; v < 8; v++) begin
      logic A, B, C;
      A = v[2]; B = v[1]; C = v[0];
      sop[v] = (A & ~B & ~C) | (A & ~B & C) | (A & B & C);
      pos[v] = (A | B | C) & (A | B | ~C) & (A | ~B | C) & (A | ~B | ~C) & (~A | ~B | C);
    end

    run_scan(sop, pos, 1'b0, 0, 1'b0, nb);
    chk("sop_pos_busy_cycles", nb, 16);
    chk("sop_pos_equal", bus0.equal, 1);
    chk("sop_pos_cnt", bus0.mismatch_cnt, 0);
`ifdef FUNC_EQUIV_TT_CAPTURE_EN
    chk("sop_tt_a", bus0.tt_a, 8'hB0);
`else
    chk("sop_tt_a", bus0.tt_a, 0);
`endif

    run_scan(sop, sop ^ 8'h20, 1'b0, 0, 1'b0, nb);
    chk("one_miss_equal", bus0.equal, 0);
    chk("one_miss_cnt", bus0.mismatch_cnt, 1);
    chk("one_miss_first", bus0.first_mismatch, 5);

    run_scan(sop, ~sop, 1'b0, 0, 1'b0, nb);
    chk("all_miss_cnt", bus0.mismatch_cnt, 8);
    chk("all_miss_first", bus0.first_mismatch, 0);

    run_scan(sop, pos, 1'b0, 5, 1'b1, nb);
    chk("restart_ignored_cycles", nb, 16);

    // reset in the middle of a scan
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus0.busy, 0);
    chk("midrst_done", bus0.done, 0);
    chk("midrst_vec", bus0.vec, 0);
    chk("midrst_cnt", bus0.mismatch_cnt, 0);
    chk("midrst_tt_a", bus0.tt_a, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    run_scan(sop, sop ^ 8'h0A, 1'b1, 0, 1'b0, nb);
    chk("post_rst_first", bus0.first_mismatch, 1);

    for (int i = 0; i < 12; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 2) == 0) ? a : (a ^ 8'($urandom));
      run_scan(a, b, 1'b1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 16)) : 0,
               1'($urandom), nb);
      chk("rand_busy_cycles", nb, NV0 * S0);
    end

    mode1 = 1'b0;
    run1(nb);
    chk("s1_busy_cycles", nb, NV1 * S1);
    chk("s1_equal", bus1.equal, 1);
    chk("s1_cnt", bus1.mismatch_cnt, 0);
`ifdef FUNC_EQUIV_TT_CAPTURE_EN
    chk("s1_tt_a", bus1.tt_a, 16'hAAAA);
`else
    chk("s1_tt_a", bus1.tt_a, 0);
`endif
    @(negedge clk);
    mode1 = 1'b1;
    run1(nb);
    chk("s1_inv_done", bus1.done, 1);
    chk("s1_inv_equal", bus1.equal, 0);
    chk("s1_inv_cnt", bus1.mismatch_cnt, 16);
    chk("s1_inv_first", bus1.first_mismatch, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
